// File: rtl/ga_irqgen_plus.sv
// Gate-array interrupt generator: periodic line interrupt with VSYNC resync,
// raster-line compare interrupt, and HSYNC/VSYNC output shaping.
module ga_irqgen_plus #(
  parameter int LINE_PERIOD = 52,
  parameter int CNT_W       = 6,
  parameter int VS_DELAY    = 2,
  parameter int HS_DELAY    = 2,
  parameter int HS_MAX      = 4,
  parameter int PRI_W       = 8
) (
  input  logic             clk_16,
  input  logic             reset,
  input  logic             cclk_en,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             irq_ack,
  input  logic             irq_clr,
  input  logic             pri_en,
  input  logic [PRI_W-1:0] pri_line,
  output logic             int_n,
  output logic             irq_src,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [CNT_W-1:0] line_cnt,
  output logic [PRI_W-1:0] raster_line
);

  localparam int VD_W  = $clog2(VS_DELAY + 2);
  localparam int HC_MX = (HS_DELAY > HS_MAX) ? HS_DELAY : HS_MAX;
  localparam int HC_W  = $clog2(HC_MX + 2);

  typedef enum logic [1:0] {HS_IDLE, HS_DLY, HS_ON} hs_state_t;

  logic             hs_s, vs_s;
  logic             hs_rise, hs_end, vs_rise;
  logic             pp, rp, vd_act;
  logic [VD_W-1:0]  vd;
  logic             pp_n, rp_n, va_n;
  logic [VD_W-1:0]  vd_n;
  logic [CNT_W-1:0] lc_n, lc_inc;
  logic [PRI_W-1:0] rl_n;
  logic             ack_pp, ack_rp;
  hs_state_t        hs_st;
  logic [HC_W-1:0]  hcnt, hc_inc;

  assign hs_rise = cclk_en & ~hs_s & hsync_i;
  assign hs_end  = cclk_en & hs_s & ~hsync_i;
  assign vs_rise = cclk_en & ~vs_s & vsync_i;
  assign vsync_o = vs_s;
  assign irq_src = rp;
  assign lc_inc  = line_cnt + 1'b1;
  assign hc_inc  = hcnt + 1'b1;
  assign ack_rp  = irq_ack & rp;
  assign ack_pp  = irq_ack & ~rp & pp;

  always_ff @(posedge clk_16) begin
    if (reset) begin
      hs_s <= 1'b0;
      vs_s <= 1'b0;
    end else if (cclk_en) begin
      hs_s <= hsync_i;
      vs_s <= vsync_i;
    end
  end

  // Priority low to high: ack clears, hs_end counting/sets, vsync load, irq_clr.
  always_comb begin
    lc_n = line_cnt;
    rl_n = raster_line;
    pp_n = pp & ~ack_pp;
    rp_n = rp & ~ack_rp;
    vd_n = vd;
    va_n = vd_act;
    if (hs_end) begin
      if (lc_inc == CNT_W'(LINE_PERIOD)) begin
        lc_n = '0;
        if (!pri_en) pp_n = 1'b1;
      end else begin
        lc_n = lc_inc;
      end
      if (pri_en && pri_line != '0 && raster_line == pri_line) rp_n = 1'b1;
      if (raster_line != '1) rl_n = raster_line + 1'b1;
    end
    if (ack_pp) lc_n[CNT_W-1] = 1'b0;
    if (hs_end && vd_act && !vs_rise) begin
      if (vd <= VD_W'(1)) begin
        lc_n = '0;
        vd_n = '0;
        va_n = 1'b0;
        if (line_cnt[CNT_W-1] && !pri_en) pp_n = 1'b1;
      end else begin
        vd_n = vd - 1'b1;
      end
    end
    if (vs_rise) begin
      rl_n = '0;
      vd_n = VD_W'(VS_DELAY);
      va_n = 1'b1;
    end
    if (irq_clr) begin
      lc_n = '0;
      pp_n = 1'b0;
      rp_n = 1'b0;
    end
  end

  always_ff @(posedge clk_16) begin
    if (reset) begin
      line_cnt    <= '0;
      raster_line <= '0;
      pp          <= 1'b0;
      rp          <= 1'b0;
      vd          <= '0;
      vd_act      <= 1'b0;
      int_n       <= 1'b1;
    end else begin
      line_cnt    <= lc_n;
      raster_line <= rl_n;
      pp          <= pp_n;
      rp          <= rp_n;
      vd          <= vd_n;
      vd_act      <= va_n;
      int_n       <= ~(pp | rp);
    end
  end

  // hcnt counts cclk_en ticks within the delay and the high phase.
  always_ff @(posedge clk_16) begin
    if (reset) begin
      hs_st   <= HS_IDLE;
      hcnt    <= '0;
      hsync_o <= 1'b0;
    end else if (cclk_en) begin
      case (hs_st)
        HS_IDLE: begin
          if (hs_rise) begin
            hcnt <= '0;
            if (HS_DELAY == 0) begin
              hs_st   <= HS_ON;
              hsync_o <= 1'b1;
            end else begin
              hs_st <= HS_DLY;
            end
          end
        end
        HS_DLY: begin
          if (hs_end) begin
            hs_st <= HS_IDLE;
            hcnt  <= '0;
          end else if (hc_inc == HC_W'(HS_DELAY)) begin
            hs_st   <= HS_ON;
            hsync_o <= 1'b1;
            hcnt    <= '0;
          end else begin
            hcnt <= hc_inc;
          end
        end
        HS_ON: begin
          if (hs_end || hc_inc == HC_W'(HS_MAX)) begin
            hs_st   <= HS_IDLE;
            hsync_o <= 1'b0;
            hcnt    <= '0;
          end else begin
            hcnt <= hc_inc;
          end
        end
        default: begin
          hs_st   <= HS_IDLE;
          hsync_o <= 1'b0;
          hcnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ga_irqgen_plus.sv
// Directed bench for ga_irqgen_plus: periodic, late-ack, VSYNC resync, raster,
// HSYNC shaping, irq_clr collision and mid-pulse reset.
module tb_ga_irqgen_plus;

  logic       clk_16 = 1'b0;
  logic       reset, cclk_en, hsync_i, vsync_i, irq_ack, irq_clr, pri_en;
  logic [7:0] pri_line;
  logic       int_n, irq_src, hsync_o, vsync_o;
  logic [5:0] line_cnt;
  logic [7:0] raster_line;
  logic       vs_lvl;
  int         vectors = 0;
  int         miscompares = 0;

  ga_irqgen_plus #(
    .LINE_PERIOD(52), .CNT_W(6), .VS_DELAY(2),
    .HS_DELAY(2), .HS_MAX(4), .PRI_W(8)
  ) dut (
    .clk_16(clk_16), .reset(reset), .cclk_en(cclk_en),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .irq_ack(irq_ack),
    .irq_clr(irq_clr), .pri_en(pri_en), .pri_line(pri_line),
    .int_n(int_n), .irq_src(irq_src), .hsync_o(hsync_o),
    .vsync_o(vsync_o), .line_cnt(line_cnt), .raster_line(raster_line)
  );

  always #5 clk_16 = ~clk_16;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // One character clock: cclk_en for one clk_16 cycle, then three idle cycles.
  task automatic cc(input logic hs, input logic vs);
    hsync_i = hs;
    vsync_i = vs;
    cclk_en = 1'b1;
    @(negedge clk_16);
    cclk_en = 1'b0;
    repeat (3) @(negedge clk_16);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cc(1'b1, vs_lvl);
      cc(1'b0, vs_lvl);
    end
  endtask

  task automatic ack;
    irq_ack = 1'b1;
    @(negedge clk_16);
    irq_ack = 1'b0;
    repeat (2) @(negedge clk_16);
  endtask

  task automatic do_reset;
    reset = 1'b1; cclk_en = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    irq_ack = 1'b0; irq_clr = 1'b0; pri_en = 1'b0; pri_line = 8'd0; vs_lvl = 1'b0;
    repeat (3) @(negedge clk_16);
    reset = 1'b0;
    @(negedge clk_16);
  endtask

  task automatic test_reset;
    reset = 1'b1; cclk_en = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    irq_ack = 1'b0; irq_clr = 1'b0; pri_en = 1'b0; pri_line = 8'd0; vs_lvl = 1'b0;
    repeat (3) @(negedge clk_16);
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL reset_int_n: got %b want 1", int_n); end
    vectors++; if (irq_src !== 1'b0) begin miscompares++; $display("FAIL reset_irq_src: got %b want 0", irq_src); end
    vectors++; if (hsync_o !== 1'b0) begin miscompares++; $display("FAIL reset_hsync_o: got %b want 0", hsync_o); end
    vectors++; if (vsync_o !== 1'b0) begin miscompares++; $display("FAIL reset_vsync_o: got %b want 0", vsync_o); end
    vectors++; if (line_cnt !== 6'd0) begin miscompares++; $display("FAIL reset_line_cnt: got %0d want 0", line_cnt); end
    vectors++; if (raster_line !== 8'd0) begin miscompares++; $display("FAIL reset_raster: got %0d want 0", raster_line); end
    reset = 1'b0;
    @(negedge clk_16);
  endtask

  task automatic test_periodic;
    do_reset();
    pulses(51);
    vectors++; if (line_cnt !== 6'd51) begin miscompares++; $display("FAIL per_cnt51: got %0d want 51", line_cnt); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL per_no_int51: got %b want 1", int_n); end
    pulses(1);
    vectors++; if (line_cnt !== 6'd0) begin miscompares++; $display("FAIL per_wrap: got %0d want 0", line_cnt); end
    vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL per_int: got %b want 0", int_n); end
    vectors++; if (irq_src !== 1'b0) begin miscompares++; $display("FAIL per_src: got %b want 0", irq_src); end
    ack();
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL per_ack: got %b want 1", int_n); end
  endtask

  task automatic test_late_ack;
    do_reset();
    pulses(92);
    vectors++; if (line_cnt !== 6'd40) begin miscompares++; $display("FAIL late_cnt: got %0d want 40", line_cnt); end
    vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL late_int: got %b want 0", int_n); end
    ack();
    vectors++; if (line_cnt !== 6'd8) begin miscompares++; $display("FAIL late_ack_cnt: got %0d want 8", line_cnt); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL late_ack_int: got %b want 1", int_n); end
  endtask

  task automatic test_vsync_resync;
    do_reset();
    pulses(35);
    vectors++; if (line_cnt !== 6'd35) begin miscompares++; $display("FAIL vs_cnt35: got %0d want 35", line_cnt); end
    vs_lvl = 1'b1;
    cc(1'b0, 1'b1);
    vectors++; if (vsync_o !== 1'b1) begin miscompares++; $display("FAIL vs_out: got %b want 1", vsync_o); end
    pulses(1);
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL vs_early_int: got %b want 1", int_n); end
    pulses(1);
    vectors++; if (line_cnt !== 6'd0) begin miscompares++; $display("FAIL vs_resync_cnt: got %0d want 0", line_cnt); end
    vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL vs_resync_int: got %b want 0", int_n); end
    vectors++; if (raster_line !== 8'd2) begin miscompares++; $display("FAIL vs_raster: got %0d want 2", raster_line); end
    ack();
    vs_lvl = 1'b0;
    cc(1'b0, 1'b0);
    pulses(20);
    vectors++; if (line_cnt !== 6'd20) begin miscompares++; $display("FAIL vs_cnt20: got %0d want 20", line_cnt); end
    vs_lvl = 1'b1;
    cc(1'b0, 1'b1);
    pulses(2);
    vectors++; if (line_cnt !== 6'd0) begin miscompares++; $display("FAIL vs_resync2_cnt: got %0d want 0", line_cnt); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL vs_resync2_int: got %b want 1", int_n); end
    vs_lvl = 1'b0;
  endtask

  task automatic test_raster;
    do_reset();
    pri_en = 1'b1;
    pri_line = 8'd100;
    cc(1'b0, 1'b1);
    cc(1'b0, 1'b0);
    pulses(100);
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL ras_pre_int: got %b want 1", int_n); end
    vectors++; if (raster_line !== 8'd100) begin miscompares++; $display("FAIL ras_line100: got %0d want 100", raster_line); end
    vectors++; if (line_cnt !== 6'd46) begin miscompares++; $display("FAIL ras_cnt46: got %0d want 46", line_cnt); end
    pulses(1);
    vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL ras_int: got %b want 0", int_n); end
    vectors++; if (irq_src !== 1'b1) begin miscompares++; $display("FAIL ras_src: got %b want 1", irq_src); end
    ack();
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL ras_ack_int: got %b want 1", int_n); end
    vectors++; if (irq_src !== 1'b0) begin miscompares++; $display("FAIL ras_ack_src: got %b want 0", irq_src); end
    vectors++; if (line_cnt !== 6'd47) begin miscompares++; $display("FAIL ras_ack_cnt: got %0d want 47", line_cnt); end
  endtask

  task automatic test_hsync_shape;
    logic exp;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cc(k < 14, 1'b0);
      exp = (k >= 2 && k <= 5);
      vectors++; if (hsync_o !== exp) begin miscompares++; $display("FAIL hs_long k=%0d: got %b want %b", k, hsync_o, exp); end
    end
    for (int k = 0; k < 4; k++) begin
      cc(k == 0, 1'b0);
      vectors++; if (hsync_o !== 1'b0) begin miscompares++; $display("FAIL hs_short k=%0d: got %b want 0", k, hsync_o); end
    end
    for (int k = 0; k < 5; k++) begin
      cc(k < 3, 1'b0);
      exp = (k == 2);
      vectors++; if (hsync_o !== exp) begin miscompares++; $display("FAIL hs_trunc k=%0d: got %b want %b", k, hsync_o, exp); end
    end
  endtask

  task automatic test_collision;
    do_reset();
    pulses(51);
    cc(1'b1, 1'b0);
    hsync_i = 1'b0;
    cclk_en = 1'b1;
    irq_clr = 1'b1;
    @(negedge clk_16);
    cclk_en = 1'b0;
    irq_clr = 1'b0;
    repeat (3) @(negedge clk_16);
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL clr_int: got %b want 1", int_n); end
    vectors++; if (line_cnt !== 6'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", line_cnt); end
    pulses(1);
    vectors++; if (line_cnt !== 6'd1) begin miscompares++; $display("FAIL clr_next_cnt: got %0d want 1", line_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    pulses(52);
    cc(1'b1, 1'b0); cc(1'b1, 1'b0); cc(1'b1, 1'b0);
    vectors++; if (hsync_o !== 1'b1) begin miscompares++; $display("FAIL rm_hs_pre: got %b want 1", hsync_o); end
    vectors++; if (int_n !== 1'b0) begin miscompares++; $display("FAIL rm_int_pre: got %b want 0", int_n); end
    reset = 1'b1;
    @(negedge clk_16);
    vectors++; if (hsync_o !== 1'b0) begin miscompares++; $display("FAIL rm_hs: got %b want 0", hsync_o); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL rm_int: got %b want 1", int_n); end
    vectors++; if (line_cnt !== 6'd0) begin miscompares++; $display("FAIL rm_cnt: got %0d want 0", line_cnt); end
    vectors++; if (raster_line !== 8'd0) begin miscompares++; $display("FAIL rm_raster: got %0d want 0", raster_line); end
    reset = 1'b0;
    @(negedge clk_16);
    cc(1'b1, 1'b0); cc(1'b1, 1'b0);
    vectors++; if (hsync_o !== 1'b0) begin miscompares++; $display("FAIL rm_fresh_dly: got %b want 0", hsync_o); end
    cc(1'b1, 1'b0);
    vectors++; if (hsync_o !== 1'b1) begin miscompares++; $display("FAIL rm_fresh_on: got %b want 1", hsync_o); end
    vectors++; if (int_n !== 1'b1) begin miscompares++; $display("FAIL rm_no_int: got %b want 1", int_n); end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_late_ack();
    test_vsync_resync();
    test_raster();
    test_hsync_shape();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
